// File: rtl/cnt_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and its host/counter side.
// The controller uses the slave view; the host (or bench) uses the master view.
interface cnt_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic [15:0] lo_lim;
    logic [15:0] hi_lim;
    logic [7:0]  num_cycles;
    logic [15:0] cnt_in;
    logic [15:0] data_out;
    logic        ld_cnt;
    logic        updn_cnt;
    logic        count_enb;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  cycles_left;

    modport slave (
        input  start,
        input  abort,
        input  lo_lim,
        input  hi_lim,
        input  num_cycles,
        input  cnt_in,
        output data_out,
        output ld_cnt,
        output updn_cnt,
        output count_enb,
        output busy,
        output done,
        output err,
        output cycles_left
    );

    modport master (
        output start,
        output abort,
        output lo_lim,
        output hi_lim,
        output num_cycles,
        output cnt_in,
        input  data_out,
        input  ld_cnt,
        input  updn_cnt,
        input  count_enb,
        input  busy,
        input  done,
        input  err,
        input  cycles_left
    );
endinterface

// File: rtl/cnt_sweep_ctrl.sv
// Sweeps an external up/down counter between lo and hi for N up+down passes.
// Counter-control outputs are Moore-decoded from the state register.
module cnt_sweep_ctrl (
    input  logic            clk,
    input  logic            rst,
    cnt_sweep_ctrl_if.slave sw
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_lo_q;
    logic [15:0] r_hi_q;
    logic [7:0]  r_cycles_left;
    logic        r_err;

    logic        w_cfg_ok;
    logic        w_at_top;
    logic        w_at_bot;
    logic        w_accept;
    logic        w_reject;
    logic        w_turn;
    logic        w_ld_cnt;
    logic        w_updn_cnt;
    logic        w_count_enb;
    logic        w_busy;
    logic        w_done;

    assign w_cfg_ok = (sw.lo_lim < sw.hi_lim) && (sw.num_cycles != 8'd0);

    // Reverse one step early so the counter's next increment/decrement lands
    // exactly on the limit; 17-bit unsigned compares also catch overshoot.
    assign w_at_top = {1'b0, sw.cnt_in} >= ({1'b0, r_hi_q} - 17'd1);
    assign w_at_bot = {1'b0, sw.cnt_in} <= ({1'b0, r_lo_q} + 17'd1);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_turn       = 1'b0;
        w_ld_cnt     = 1'b1;
        w_updn_cnt   = 1'b0;
        w_count_enb  = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sw.start) begin
                    if (w_cfg_ok) begin
                        w_accept     = 1'b1;
                        w_state_next = S_LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_ld_cnt     = 1'b0;
                w_busy       = 1'b1;
                w_state_next = sw.abort ? S_IDLE : S_UP;
            end
            S_UP: begin
                w_count_enb = 1'b1;
                w_updn_cnt  = 1'b1;
                w_busy      = 1'b1;
                if (sw.abort) begin
                    w_state_next = S_IDLE;
                end else if (w_at_top) begin
                    w_state_next = S_DOWN;
                end
            end
            S_DOWN: begin
                w_count_enb = 1'b1;
                w_busy      = 1'b1;
                if (sw.abort) begin
                    w_state_next = S_IDLE;
                end else if (w_at_bot) begin
                    w_turn       = 1'b1;
                    w_state_next = (r_cycles_left == 8'd1) ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_lo_q        <= 16'd0;
            r_hi_q        <= 16'd0;
            r_cycles_left <= 8'd0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_lo_q        <= sw.lo_lim;
                r_hi_q        <= sw.hi_lim;
                r_cycles_left <= sw.num_cycles;
                r_err         <= 1'b0;
            end else if (w_reject) begin
                r_err <= 1'b1;
            end
            if (w_turn) begin
                r_cycles_left <= r_cycles_left - 8'd1;
            end
        end
    end

    assign sw.data_out    = r_lo_q;
    assign sw.ld_cnt      = w_ld_cnt;
    assign sw.updn_cnt    = w_updn_cnt;
    assign sw.count_enb   = w_count_enb;
    assign sw.busy        = w_busy;
    assign sw.done        = w_done;
    assign sw.err         = r_err;
    assign sw.cycles_left = r_cycles_left;
endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Bench for cnt_sweep_ctrl: drives an attached up/down counter model and
// checks whole runs from a table plus hand-written abort/reset sequences.
module tb_cnt_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] cnt_r = 16'd0;

    cnt_sweep_ctrl_if bus ();

    cnt_sweep_ctrl dut (
        .clk (clk),
        .rst (rst),
        .sw  (bus.slave)
    );

    always #5 clk = ~clk;

    // Attached counter: active-low synchronous load, enable, up/down.
    always @(posedge clk) begin
        if (!bus.ld_cnt)
            cnt_r <= bus.data_out;
        else if (bus.count_enb)
            cnt_r <= bus.updn_cnt ? cnt_r + 16'd1 : cnt_r - 16'd1;
    end
    assign bus.cnt_in = cnt_r;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [7:0]  n;
        logic        exp_err;
        int          exp_busy;
        int          exp_done;
        int          exp_ld;
        logic [15:0] exp_cnt;
        logic [7:0]  exp_cl;
    } vec_t;

    typedef struct {
        logic        updn;
        logic [7:0]  cl;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } cyc_t;

    vec_t tbl [8];
    vec_t exp_q [$];
    cyc_t cyc_q [$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_run(input vec_t v);
        int   busy_n = 0;
        int   done_n = 0;
        int   ld_n   = 0;
        int   guard  = 0;
        int   post   = -1;
        logic ld_val_ok = 1'b1;
        vec_t e;
        exp_q.push_back(v);
        @(negedge clk);
        bus.lo_lim = v.lo; bus.hi_lim = v.hi; bus.num_cycles = v.n; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (1) begin
            if (bus.busy) busy_n++;
            if (!bus.ld_cnt) begin
                ld_n++;
                if (bus.data_out !== v.lo) ld_val_ok = 1'b0;
            end
            if (bus.done) done_n++;
            // A start with new limits mid-run must be ignored.
            if (guard == 3 && bus.busy) begin
                bus.start      = 1'b1;
                bus.lo_lim     = 16'($urandom_range(0, 50));
                bus.hi_lim     = bus.lo_lim + 16'($urandom_range(1, 50));
                bus.num_cycles = 8'($urandom_range(1, 9));
            end else begin
                bus.start = 1'b0;
            end
            if (post == 0) break;
            if (post > 0) post--;
            if (bus.done && post < 0) post = 2;
            if (v.exp_err && guard >= 5) break;
            if (guard >= 3000) break;
            guard++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        e = exp_q.pop_front();
        $display("run lo=%0d hi=%0d n=%0d: busy=%0d done=%0d err=%0d cnt=%0d",
                 v.lo, v.hi, v.n, busy_n, done_n, bus.err, cnt_r);
        check("run_timeout", (guard >= 3000) ? 32'd1 : 32'd0, 32'd0);
        check("run_err", bus.err, e.exp_err);
        check("run_busy_cycles", busy_n, e.exp_busy);
        check("run_done_pulses", done_n, e.exp_done);
        check("run_ld_cycles", ld_n, e.exp_ld);
        check("run_ld_data", ld_val_ok, 1'b1);
        check("run_final_cnt", cnt_r, e.exp_cnt);
        check("run_cycles_left", bus.cycles_left, e.exp_cl);
        check("run_idle_busy", bus.busy, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_out"}, bus.data_out, 16'd0);
        check({tag, "_ld_cnt"}, bus.ld_cnt, 1'b1);
        check({tag, "_updn_cnt"}, bus.updn_cnt, 1'b0);
        check({tag, "_count_enb"}, bus.count_enb, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_err"}, bus.err, 1'b0);
        check({tag, "_cycles_left"}, bus.cycles_left, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   guard;
        int   done_n;
        cyc_t c;
        cyc_t g;

        //             lo     hi     n   err busy done ld cnt    cl
        tbl[0] = '{16'd7,     16'd10,    8'd1, 1'b0, 7,  1, 1, 16'd7,     8'd0};
        tbl[1] = '{16'd10,    16'd7,     8'd1, 1'b1, 0,  0, 0, 16'd7,     8'd0};
        tbl[2] = '{16'd3,     16'd5,     8'd2, 1'b0, 9,  1, 1, 16'd3,     8'd0};
        tbl[3] = '{16'd5,     16'd5,     8'd1, 1'b1, 0,  0, 0, 16'd3,     8'd0};
        tbl[4] = '{16'd1,     16'd4,     8'd0, 1'b1, 0,  0, 0, 16'd3,     8'd0};
        tbl[5] = '{16'd100,   16'd104,   8'd3, 1'b0, 25, 1, 1, 16'd100,   8'd0};
        tbl[6] = '{16'd65530, 16'd65535, 8'd1, 1'b0, 11, 1, 1, 16'd65530, 8'd0};
        tbl[7] = '{16'd0,     16'd1,     8'd2, 1'b0, 5,  1, 1, 16'd0,     8'd0};

        bus.start = 1'b0; bus.abort = 1'b0;
        bus.lo_lim = 16'd0; bus.hi_lim = 16'd0; bus.num_cycles = 8'd0;

        // Reset held two cycles with random inputs.
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1; bus.abort = 1'($urandom_range(0, 1));
        bus.lo_lim = 16'($urandom); bus.hi_lim = 16'($urandom); bus.num_cycles = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        $display("reset: held 2 cycles with random inputs");
        check_reset_values("rst");
        rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_run(tbl[i]);
        end

        // lo=0, hi=1, N=3: direction alternates, cycles_left counts down.
        cyc_q.push_back('{1'b0, 8'd3, 1'b1, 1'b0, 16'd0});
        cyc_q.push_back('{1'b1, 8'd3, 1'b1, 1'b0, 16'd0});
        cyc_q.push_back('{1'b0, 8'd3, 1'b1, 1'b0, 16'd1});
        cyc_q.push_back('{1'b1, 8'd2, 1'b1, 1'b0, 16'd0});
        cyc_q.push_back('{1'b0, 8'd2, 1'b1, 1'b0, 16'd1});
        cyc_q.push_back('{1'b1, 8'd1, 1'b1, 1'b0, 16'd0});
        cyc_q.push_back('{1'b0, 8'd1, 1'b1, 1'b0, 16'd1});
        cyc_q.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 16'd0});
        cyc_q.push_back('{1'b0, 8'd0, 1'b0, 1'b0, 16'd0});
        @(negedge clk);
        bus.lo_lim = 16'd0; bus.hi_lim = 16'd1; bus.num_cycles = 8'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            c = cyc_q.pop_front();
            g = '{bus.updn_cnt, bus.cycles_left, bus.busy, bus.done, cnt_r};
            $display("alt cycle %0d: updn=%0d cl=%0d busy=%0d done=%0d cnt=%0d",
                     k, g.updn, g.cl, g.busy, g.done, g.cnt);
            check("alt_updn", g.updn, c.updn);
            check("alt_cycles_left", g.cl, c.cl);
            check("alt_busy", g.busy, c.busy);
            check("alt_done", g.done, c.done);
            check("alt_cnt", g.cnt, c.cnt);
            @(negedge clk);
        end

        // Abort in UP with cnt_in=9 on lo=0, hi=20, N=1.
        bus.lo_lim = 16'd0; bus.hi_lim = 16'd20; bus.num_cycles = 8'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!(bus.count_enb && bus.updn_cnt && cnt_r == 16'd9) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("abort_reach_timeout", (guard >= 100) ? 32'd1 : 32'd0, 32'd0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        $display("abort: busy=%0d enb=%0d cl=%0d cnt=%0d", bus.busy, bus.count_enb, bus.cycles_left, cnt_r);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_count_enb", bus.count_enb, 1'b0);
        check("abort_cycles_left", bus.cycles_left, 8'd1);
        done_n = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.done) done_n++;
            @(negedge clk);
        end
        check("abort_no_done", done_n, 0);
        check("abort_cnt_hold", cnt_r, 16'd10);
        check("abort_ld_cnt", bus.ld_cnt, 1'b1);

        // Reset mid-DOWN, overriding start and abort.
        bus.lo_lim = 16'd2; bus.hi_lim = 16'd6; bus.num_cycles = 8'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!(bus.count_enb && !bus.updn_cnt) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("down_reach_timeout", (guard >= 100) ? 32'd1 : 32'd0, 32'd0);
        rst = 1'b1; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        $display("reset mid-DOWN: busy=%0d cl=%0d data_out=%0d", bus.busy, bus.cycles_left, bus.data_out);
        check_reset_values("rst_mid");
        rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;

        // New run with a mid-run start that must neither restart nor extend it.
        do_run('{16'd2, 16'd4, 8'd1, 1'b0, 5, 1, 1, 16'd2, 8'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
